exe_stage: RTL and testbench

- Execute stage directly downstream of the ID/EXE pipeline register; consumes its exe_* outputs.
- Performs single-cycle ALU ops, BEQ/BNE resolution and an iterative 32-cycle multiply that stalls the front end.
- Registers results into the EXE/MEM boundary for the memory stage.

---
 rtl/exe_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
//
// Execute stage sitting directly behind the ID/EXE pipeline register. It
// performs single-cycle ALU operations, resolves BEQ/BNE, and runs an
// iterative shift-add multiply that stalls the front end. Results are
// registered into the EXE/MEM boundary for the memory stage.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   exe_*               ID/EXE register outputs (operands, opcode, control)
//   mem_*               registered EXE/MEM outputs
//   stall_req           comb; hold PC, IF/ID and ID/EXE while a MUL runs
//   branch_taken        comb; flush IF/ID and ID/EXE and redirect the PC
//   branch_target       comb; the precomputed branch address
//
// Multiply timing: a MUL seen in IDLE at cycle C stalls cycles C..C+32
// (IDLE + 32 MUL_BUSY iterations); MUL_DONE at C+33 loads the product.
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  exe_pc_o,
    input  logic [DATA_W-1:0]  exe_branch_addr,
    input  logic [RADDR_W-1:0] exe_write_addr_o,
    input  logic [DATA_W-1:0]  exe_reg1_o,
    input  logic [DATA_W-1:0]  exe_reg2_o,
    input  logic [CTRL_W-1:0]  exe_aluctrl,
    input  logic [DATA_W-1:0]  exe_sw_o,
    input  logic [DATA_W-1:0]  exe_write_o,
    input  logic               exe_lwsrc,
    input  logic               exe_movsrc,
    input  logic               exe_reg_write,
    input  logic               exe_DM_read,
    input  logic               exe_DM_write,
    output logic [DATA_W-1:0]  mem_alu_result,
    output logic [DATA_W-1:0]  mem_sw_data,
    output logic [RADDR_W-1:0] mem_write_addr,
    output logic               mem_lwsrc,
    output logic               mem_reg_write,
    output logic               mem_DM_read,
    output logic               mem_DM_write,
    output logic               stall_req,
    output logic               branch_taken,
    output logic [DATA_W-1:0]  branch_target
);

    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] OP_BEQ = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] OP_BNE = CTRL_W'(12);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]  mcand_q,  mcand_d;
    logic [DATA_W-1:0]  mplier_q, mplier_d;
    logic [DATA_W-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [DATA_W-1:0]  mem_alu_result_q, mem_alu_result_d;
    logic [DATA_W-1:0]  mem_sw_data_q,    mem_sw_data_d;
    logic [RADDR_W-1:0] mem_write_addr_q, mem_write_addr_d;
    logic               mem_lwsrc_q,      mem_lwsrc_d;
    logic               mem_reg_write_q,  mem_reg_write_d;
    logic               mem_DM_read_q,    mem_DM_read_d;
    logic               mem_DM_write_q,   mem_DM_write_d;

    logic [DATA_W-1:0]  alu_res;
    logic [DATA_W-1:0]  exe_res;
    logic [DATA_W-1:0]  result_sel;
    logic               load_en;
    logic               stall_int;
    logic [SHAMT_W-1:0] shamt;
    logic               is_mul;
    logic               operands_eq;

    // The PC is carried by ID/EXE for other consumers; nothing here needs it.
    logic               unused_pc;
    assign unused_pc = ^exe_pc_o;

    assign shamt       = exe_reg2_o[SHAMT_W-1:0];
    assign is_mul      = (exe_aluctrl == OP_MUL);
    assign operands_eq = (exe_reg1_o == exe_reg2_o);

    // ------------------------------------------------------------------ ALU
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (exe_aluctrl)
            OP_ADD:  alu_res = exe_reg1_o + exe_reg2_o;
            OP_SUB:  alu_res = exe_reg1_o - exe_reg2_o;
            OP_AND:  alu_res = exe_reg1_o & exe_reg2_o;
            OP_OR:   alu_res = exe_reg1_o | exe_reg2_o;
            OP_XOR:  alu_res = exe_reg1_o ^ exe_reg2_o;
            OP_SLL:  alu_res = exe_reg1_o << shamt;
            OP_SRL:  alu_res = exe_reg1_o >> shamt;
            OP_SRA:  alu_res = $signed(exe_reg1_o) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(exe_reg1_o) < $signed(exe_reg2_o))};
            // NOP, MUL (produced by the FSM), BEQ/BNE and reserved codes
            default: alu_res = '0;
        endcase
    end

    // --------------------------------------------------------------- branch
    // Reset masks the flush so a random ID/EXE value cannot redirect the PC.
    assign branch_taken  = rst & (((exe_aluctrl == OP_BEQ) &  operands_eq) |
                                  ((exe_aluctrl == OP_BNE) & ~operands_eq));
    assign branch_target = exe_branch_addr;

    // ------------------------------------------------------- state register
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            mcand_q          <= '0;
            mplier_q         <= '0;
            acc_q            <= '0;
            cnt_q            <= '0;
            mem_alu_result_q <= '0;
            mem_sw_data_q    <= '0;
            mem_write_addr_q <= '0;
            mem_lwsrc_q      <= 1'b0;
            mem_reg_write_q  <= 1'b0;
            mem_DM_read_q    <= 1'b0;
            mem_DM_write_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            mcand_q          <= mcand_d;
            mplier_q         <= mplier_d;
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_sw_data_q    <= mem_sw_data_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_lwsrc_q      <= mem_lwsrc_d;
            mem_reg_write_q  <= mem_reg_write_d;
            mem_DM_read_q    <= mem_DM_read_d;
            mem_DM_write_q   <= mem_DM_write_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (cnt_q == CNT_LAST) state_d = MUL_DONE;
            MUL_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ------------------------------------------------ datapath and outputs
    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        load_en   = 1'b0;
        exe_res   = alu_res;

        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    stall_int = 1'b1;
                    mcand_d   = exe_reg1_o;
                    mplier_d  = exe_reg2_o;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    load_en   = 1'b1;
                end
            end
            MUL_BUSY: begin
                // One shift-add step per cycle; the final step (cnt==last)
                // lands in acc_q on the edge that enters MUL_DONE.
                stall_int = 1'b1;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
            end
            MUL_DONE: begin
                // Operands were latched; control fields are still held in
                // ID/EXE by the stall and are re-read here.
                load_en   = 1'b1;
                exe_res   = acc_q;
            end
            default: ;
        endcase

        result_sel = exe_movsrc ? exe_write_o : exe_res;

        if (load_en) begin
            mem_alu_result_d = result_sel;
            mem_sw_data_d    = exe_sw_o;
            mem_write_addr_d = exe_write_addr_o;
            mem_lwsrc_d      = exe_lwsrc;
            mem_reg_write_d  = exe_reg_write;
            mem_DM_read_d    = exe_DM_read;
            mem_DM_write_d   = exe_DM_write;
        end else begin
            // Bubble: nothing architectural may happen in MEM/WB.
            mem_alu_result_d = '0;
            mem_sw_data_d    = '0;
            mem_write_addr_d = '0;
            mem_lwsrc_d      = 1'b0;
            mem_reg_write_d  = 1'b0;
            mem_DM_read_d    = 1'b0;
            mem_DM_write_d   = 1'b0;
        end
    end

    assign stall_req      = rst & stall_int;

    assign mem_alu_result = mem_alu_result_q;
    assign mem_sw_data    = mem_sw_data_q;
    assign mem_write_addr = mem_write_addr_q;
    assign mem_lwsrc      = mem_lwsrc_q;
    assign mem_reg_write  = mem_reg_write_q;
    assign mem_DM_read    = mem_DM_read_q;
    assign mem_DM_write   = mem_DM_write_q;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
//
// Self-checking bench for exe_stage. Expected EXE/MEM writes are queued when
// an instruction is driven and popped by a monitor whenever the DUT presents
// mem_reg_write=1. Combinational outputs (stall_req, branch_*) are checked
// directly at the falling edge.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_BEQ = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] exe_pc_o, exe_branch_addr, exe_reg1_o, exe_reg2_o;
    logic [31:0] exe_sw_o, exe_write_o;
    logic [4:0]  exe_write_addr_o;
    logic [3:0]  exe_aluctrl;
    logic        exe_lwsrc, exe_movsrc, exe_reg_write, exe_DM_read, exe_DM_write;
    logic [31:0] mem_alu_result, mem_sw_data, branch_target;
    logic [4:0]  mem_write_addr;
    logic        mem_lwsrc, mem_reg_write, mem_DM_read, mem_DM_write;
    logic        stall_req, branch_taken;

    typedef struct {
        logic [31:0] result;
        logic [31:0] sw;
        logic [4:0]  waddr;
        logic        lwsrc;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .exe_pc_o         (exe_pc_o),
        .exe_branch_addr  (exe_branch_addr),
        .exe_write_addr_o (exe_write_addr_o),
        .exe_reg1_o       (exe_reg1_o),
        .exe_reg2_o       (exe_reg2_o),
        .exe_aluctrl      (exe_aluctrl),
        .exe_sw_o         (exe_sw_o),
        .exe_write_o      (exe_write_o),
        .exe_lwsrc        (exe_lwsrc),
        .exe_movsrc       (exe_movsrc),
        .exe_reg_write    (exe_reg_write),
        .exe_DM_read      (exe_DM_read),
        .exe_DM_write     (exe_DM_write),
        .mem_alu_result   (mem_alu_result),
        .mem_sw_data      (mem_sw_data),
        .mem_write_addr   (mem_write_addr),
        .mem_lwsrc        (mem_lwsrc),
        .mem_reg_write    (mem_reg_write),
        .mem_DM_read      (mem_DM_read),
        .mem_DM_write     (mem_DM_write),
        .stall_req        (stall_req),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_mem_zero(input string tag);
        check({tag, "_result"}, mem_alu_result, 32'd0);
        check({tag, "_sw"},     mem_sw_data,    32'd0);
        check({tag, "_waddr"},  32'(mem_write_addr), 32'd0);
        check({tag, "_ctrl"},   {28'd0, mem_lwsrc, mem_reg_write, mem_DM_read, mem_DM_write}, 32'd0);
    endtask

    task automatic set_idle();
        exe_pc_o         = '0;
        exe_branch_addr  = '0;
        exe_write_addr_o = '0;
        exe_reg1_o       = '0;
        exe_reg2_o       = '0;
        exe_aluctrl      = OP_NOP;
        exe_sw_o         = '0;
        exe_write_o      = '0;
        exe_lwsrc        = 1'b0;
        exe_movsrc       = 1'b0;
        exe_reg_write    = 1'b0;
        exe_DM_read      = 1'b0;
        exe_DM_write     = 1'b0;
    endtask

    task automatic drive_random();
        exe_pc_o         = $urandom;
        exe_branch_addr  = $urandom;
        exe_write_addr_o = 5'($urandom);
        exe_reg1_o       = $urandom;
        exe_reg2_o       = $urandom;
        exe_aluctrl      = 4'($urandom);
        exe_sw_o         = $urandom;
        exe_write_o      = $urandom;
        exe_lwsrc        = 1'($urandom);
        exe_movsrc       = 1'($urandom);
        exe_reg_write    = 1'b1;
        exe_DM_read      = 1'($urandom);
        exe_DM_write     = 1'($urandom);
    endtask

    // Drive one instruction that writes a register and queue its expectation.
    task automatic drive_wr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic mov, input logic [31:0] wv, input logic [31:0] exp);
        sb_entry_t e;
        exe_pc_o         = $urandom;
        exe_branch_addr  = $urandom;
        exe_write_addr_o = 5'($urandom_range(1, 31));
        exe_reg1_o       = a;
        exe_reg2_o       = b;
        exe_aluctrl      = op;
        exe_sw_o         = $urandom;
        exe_write_o      = wv;
        exe_lwsrc        = 1'($urandom);
        exe_movsrc       = mov;
        exe_reg_write    = 1'b1;
        exe_DM_read      = 1'b0;
        exe_DM_write     = 1'b0;
        e.result = exp;
        e.sw     = exe_sw_o;
        e.waddr  = exe_write_addr_o;
        e.lwsrc  = exe_lwsrc;
        sb_q.push_back(e);
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mov, input logic [31:0] wv, input logic [31:0] exp);
        drive_wr(op, a, b, mov, wv, exp);
        @(negedge clk);
        check("alu_no_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
    endtask

    // Issue a MUL, count stalled cycles and confirm bubbles behind it.
    task automatic mul(input logic [31:0] a, input logic [31:0] b,
                       input logic mov, input logic [31:0] wv, input logic [31:0] exp);
        int  n    = 0;
        bit  done = 0;
        drive_wr(OP_MUL, a, b, mov, wv, exp);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_req) begin
                n++;
                if (i >= 1) check("mul_bubble", 32'(mem_reg_write), 32'd0);
            end else begin
                done = 1;
            end
            @(posedge clk); #1;
        end
        check("mul_stall_cycles", 32'(n), 32'd33);
    endtask

    task automatic branch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mov, input logic [31:0] tgt, input logic exp_taken);
        set_idle();
        exe_aluctrl     = op;
        exe_reg1_o      = a;
        exe_reg2_o      = b;
        exe_movsrc      = mov;
        exe_write_o     = 32'h0000_BEEF;
        exe_branch_addr = tgt;
        @(negedge clk);
        check("br_taken",  32'(branch_taken), 32'(exp_taken));
        check("br_target", branch_target, tgt);
        check("br_stall",  32'(stall_req), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: every register write leaving EXE/MEM must match.
    always @(posedge clk) begin
        #2;
        if (mem_reg_write) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_write", 32'(mem_reg_write), 32'd0);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check("sb_result", mem_alu_result, e.result);
                check("sb_sw",     mem_sw_data,    e.sw);
                check("sb_waddr",  32'(mem_write_addr), 32'(e.waddr));
                check("sb_lwsrc",  32'(mem_lwsrc), 32'(e.lwsrc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset with random inputs
        rst = 1'b0;
        drive_random();
        exe_aluctrl = OP_MUL;
        @(posedge clk); #1;
        exe_aluctrl = OP_MUL;
        @(negedge clk);
        check("rst_stall", 32'(stall_req), 32'd0);
        check_mem_zero("rst_c1");
        @(posedge clk); #1;
        drive_random();
        exe_aluctrl = OP_BEQ;
        exe_reg2_o  = exe_reg1_o;
        @(negedge clk);
        check("rst_branch", 32'(branch_taken), 32'd0);
        check("rst_stall2", 32'(stall_req), 32'd0);
        check_mem_zero("rst_c2");
        @(posedge clk); #1;
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;

        // ---------------- ALU sweep
        alu(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h0000_0000);
        alu(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0, 32'hFFFF_FFFF);
        alu(OP_SRA, 32'h8000_0000, 32'h0000_0004, 1'b0, 32'h0, 32'hF800_0000);
        alu(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, 32'h0000_0001);
        alu(OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0000_0000);
        alu(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0, 32'h0000_F000);
        alu(OP_OR,  32'h0000_F0F0, 32'h0000_0F0F, 1'b0, 32'h0, 32'h0000_FFFF);
        alu(OP_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h5555_AAAA);
        alu(OP_SLL, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
        alu(OP_SRL, 32'h8000_0000, 32'h0000_001F, 1'b0, 32'h0, 32'h0000_0001);
        alu(OP_NOP, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0, 32'h0000_0000);
        alu(4'd14,  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0, 32'h0000_0000);
        alu(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h0000_1234, 32'h0000_1234);

        // ---------------- multiply, including back-to-back
        mul(32'h0001_0003, 32'h0000_0005, 1'b0, 32'h0, 32'h0005_000F);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0000_0001);
        mul(32'h1234_5678, 32'h0000_0010, 1'b0, 32'h0, 32'h2345_6780);
        mul(32'h0000_0007, 32'h0000_0006, 1'b1, 32'h0000_1234, 32'h0000_1234);
        alu(OP_ADD, 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0, 32'h0000_0030);

        // ---------------- branches
        branch(OP_BEQ, 32'd7, 32'd7, 1'b0, 32'h0000_0040, 1'b1);
        branch(OP_BNE, 32'd7, 32'd7, 1'b0, 32'h0000_0040, 1'b0);
        branch(OP_BNE, 32'd7, 32'd8, 1'b0, 32'h0000_0080, 1'b1);
        branch(OP_BEQ, 32'd7, 32'd8, 1'b0, 32'h0000_00C0, 1'b0);
        branch(OP_BEQ, 32'd5, 32'd5, 1'b1, 32'h0000_0100, 1'b1);
        check("br_bubble", 32'(mem_reg_write), 32'd0);

        // ---------------- reset in the middle of a multiply
        set_idle();
        exe_aluctrl   = OP_MUL;
        exe_reg1_o    = 32'h0000_0003;
        exe_reg2_o    = 32'h0000_0003;
        exe_reg_write = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        check("midmul_busy_stall", 32'(stall_req), 32'd1);
        rst = 1'b0;
        #1;
        check("midmul_rst_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        check("midmul_idle_stall", 32'(stall_req), 32'd0);
        check_mem_zero("midmul");
        @(posedge clk); #1;
        alu(OP_ADD, 32'd2, 32'd3, 1'b0, 32'h0, 32'd5);

        // ---------------- drain
        set_idle();
        repeat (3) @(posedge clk);
        #3;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
